// File: rtl/dac_pkg.sv
// Shared types, default sizes and the midscale helper for the dual-channel DAC interface.
// Build option: define DAC_OFFSET_BINARY_EN for offset-binary output codes (default: two's complement).
package dac_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_DIV        = 4;

`ifdef DAC_OFFSET_BINARY_EN
    localparam bit OFFSET_BINARY_EN = 1'b1;
`else
    localparam bit OFFSET_BINARY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } dac_state_e;

    // DAC code for a zero sample; in offset-binary mode this is also the MSB flip mask.
    function automatic logic [31:0] midscale(input int width);
        return OFFSET_BINARY_EN ? (32'd1 << (width - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/dac_clk_div.sv
// Update-period divider: phase counter 0..DIV-1, update tick on the last phase,
// and the DAC clock/write strobe during the second half of each period.
module dac_clk_div
    import dac_pkg::*;
#(
    parameter int DIV = DEF_DIV,
    localparam int CNT_W = $clog2(DIV)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             strobe
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; blocking is kept to always_comb.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign tick   = run && (cnt_q == LAST);
    assign strobe = run && (cnt_q >= HALF);

endmodule

// File: rtl/dac_dual_if.sv
// Dual-channel DAC interface: single-entry input buffer, paced sample delivery every DIV cycles,
// underrun detection/counting. Build option: DAC_OFFSET_BINARY_EN (offset-binary output codes).
module dac_dual_if
    import dac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIV        = DEF_DIV
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  clear_in,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_dataA,
    input  logic [DATA_WIDTH-1:0] s_dataB,
    output logic [DATA_WIDTH-1:0] dac_dataA_out,
    output logic [DATA_WIDTH-1:0] dac_dataB_out,
    output logic                  dac_clk_out,
    output logic                  dac_wrt_out,
    output logic                  underrun_out,
    output logic [15:0]           underrun_cnt
);

    localparam int CNT_W = $clog2(DIV);
    // Zero-sample code; XOR with it converts two's complement to the output code in either mode.
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(midscale(DATA_WIDTH));

    dac_state_e            state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] buf_a_q, buf_a_d;
    logic [DATA_WIDTH-1:0] buf_b_q, buf_b_d;
    logic [DATA_WIDTH-1:0] dac_a_q, dac_a_d;
    logic [DATA_WIDTH-1:0] dac_b_q, dac_b_d;
    logic                  underrun_q, underrun_d;
    logic [15:0]           urun_cnt_q, urun_cnt_d;

    logic                  run;
    logic                  tick;
    logic                  strobe;
    logic                  load;
    logic                  urun_event;
    logic [CNT_W-1:0]      div_cnt_unused;

    assign run     = (state_q != ST_IDLE);
    assign s_ready = !buf_valid_q && enable_in;

    dac_clk_div #(
        .DIV (DIV)
    ) u_clk_div (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .run    (run),
        .cnt    (div_cnt_unused),
        .tick   (tick),
        .strobe (strobe)
    );

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_a_d     = buf_a_q;
        buf_b_d     = buf_b_q;
        dac_a_d     = dac_a_q;
        dac_b_d     = dac_b_q;
        underrun_d  = underrun_q;
        urun_cnt_d  = urun_cnt_q;
        load        = 1'b0;
        urun_event  = 1'b0;

        if (s_valid && s_ready) begin
            buf_valid_d = 1'b1;
            buf_a_d     = s_dataA;
            buf_b_d     = s_dataB;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable_in && buf_valid_q) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_UNDERRUN: begin
                if (tick) begin
                    // Disable wins at the period boundary; any buffered pair is kept for restart.
                    if (!enable_in) begin
                        state_d = ST_IDLE;
                        dac_a_d = MIDSCALE;
                        dac_b_d = MIDSCALE;
                    end else if (buf_valid_q) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_UNDERRUN;
                        urun_event = (state_q == ST_RUN);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // load needs buf_valid_q set, a transfer needs it clear, so the two never collide.
        if (load) begin
            dac_a_d     = buf_a_q ^ MIDSCALE;
            dac_b_d     = buf_b_q ^ MIDSCALE;
            buf_valid_d = 1'b0;
        end

        if (clear_in) begin
            underrun_d = 1'b0;
            urun_cnt_d = '0;
        end else if (urun_event) begin
            underrun_d = 1'b1;
            if (urun_cnt_q != 16'hFFFF) begin
                urun_cnt_d = urun_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            dac_a_q     <= MIDSCALE;
            dac_b_q     <= MIDSCALE;
            underrun_q  <= 1'b0;
            urun_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            dac_a_q     <= dac_a_d;
            dac_b_q     <= dac_b_d;
            underrun_q  <= underrun_d;
            urun_cnt_q  <= urun_cnt_d;
        end
    end

    // NOTE: buffer payload has no reset; buf_valid_q alone qualifies it, so reset stays off the datapath.
    always_ff @(posedge clk_in) begin
        buf_a_q <= buf_a_d;
        buf_b_q <= buf_b_d;
    end

    assign dac_dataA_out = dac_a_q;
    assign dac_dataB_out = dac_b_q;
    assign dac_clk_out   = strobe;
    assign dac_wrt_out   = strobe;
    assign underrun_out  = underrun_q;
    assign underrun_cnt  = urun_cnt_q;

endmodule

// File: tb/tb_dac_dual_if.sv
// Self-checking bench for dac_dual_if: hand-written vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dac_dual_if;

    localparam int W   = 14;
    localparam int DIV = 4;
`ifdef DAC_OFFSET_BINARY_EN
    localparam bit OB = 1'b1;
`else
    localparam bit OB = 1'b0;
`endif
    localparam logic [W-1:0] MID = OB ? 14'h2000 : 14'h0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         v = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic [W-1:0] da, db;
    logic         dclk, dwrt, uflag;
    logic [15:0]  ucnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dac_dual_if #(
        .DATA_WIDTH (W),
        .DIV        (DIV)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .enable_in     (en),
        .clear_in      (clr),
        .s_valid       (v),
        .s_ready       (ready),
        .s_dataA       (a),
        .s_dataB       (b),
        .dac_dataA_out (da),
        .dac_dataB_out (db),
        .dac_clk_out   (dclk),
        .dac_wrt_out   (dwrt),
        .underrun_out  (uflag),
        .underrun_cnt  (ucnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_run, m_starved;
    int           m_age;
    logic [W-1:0] mq_a[$];
    logic [W-1:0] mq_b[$];
    logic [W-1:0] m_out_a, m_out_b;
    bit           m_flag;
    int           m_cnt;

    function automatic logic [W-1:0] conv(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x;
        if (OB) y[W-1] = ~x[W-1];
        return y;
    endfunction

    task automatic model_reset();
        m_run = 0; m_starved = 0; m_age = 0;
        mq_a.delete(); mq_b.delete();
        m_out_a = MID; m_out_b = MID;
        m_flag = 0; m_cnt = 0;
    endtask

    function automatic bit model_strobe();
        return m_run && ((m_age % DIV) >= DIV / 2);
    endfunction

    task automatic model_check();
        check("m_dac_a", 32'(da), 32'(m_out_a));
        check("m_dac_b", 32'(db), 32'(m_out_b));
        check("m_dac_clk", 32'(dclk), 32'(model_strobe()));
        check("m_dac_wrt", 32'(dwrt), 32'(model_strobe()));
        check("m_underrun", 32'(uflag), 32'(m_flag));
        check("m_underrun_cnt", 32'(ucnt), 32'(m_cnt));
        check("m_s_ready", 32'(ready), 32'((mq_a.size() == 0) && en));
    endtask

    task automatic model_step();
        bit rdy, tck, ev, ld;
        rdy = (mq_a.size() == 0) && en;
        tck = m_run && ((m_age % DIV) == DIV - 1);
        ev  = 0;
        ld  = 0;
        if (!m_run) begin
            if (en && mq_a.size() != 0) begin
                ld = 1; m_run = 1; m_starved = 0; m_age = 0;
            end
        end else begin
            m_age++;
            if (tck) begin
                if (!en) begin
                    m_run = 0; m_age = 0; m_out_a = MID; m_out_b = MID;
                end else if (mq_a.size() != 0) begin
                    ld = 1; m_starved = 0;
                end else begin
                    if (!m_starved) ev = 1;
                    m_starved = 1;
                end
            end
        end
        if (ld) begin
            m_out_a = conv(mq_a.pop_front());
            m_out_b = conv(mq_b.pop_front());
        end
        if (v && rdy) begin
            mq_a.push_back(a);
            mq_b.push_back(b);
        end
        if (clr) begin
            m_flag = 0; m_cnt = 0;
        end else if (ev) begin
            m_flag = 1;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    // Drive inputs mid-cycle, then compare against the model before the next rising edge.
    task automatic drive(input bit r, input bit e, input bit c, input bit vv,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        rst = r; en = e; clr = c; v = vv; a = aa; b = bb;
        #1;
        model_check();
    endtask

    task automatic advance();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit           en;
        bit           v;
        logic [W-1:0] a, b;
        logic [W-1:0] exp_a, exp_b;
        bit           exp_strobe;
        bit           exp_ready;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        logic [W-1:0] hold_a;

        model_reset();
        @(negedge clk);
        drive(1, 0, 0, 0, '0, '0); advance();
        drive(1, 0, 0, 0, '0, '0); advance();

        // Reset state
        drive(0, 0, 0, 0, '0, '0);
        check("rst_dac_a", 32'(da), 32'(MID));
        check("rst_dac_b", 32'(db), 32'(MID));
        check("rst_strobe", 32'({dclk, dwrt}), 32'd0);
        check("rst_underrun_cnt", 32'(ucnt), 32'd0);
        check("rst_underrun", 32'(uflag), 32'd0);
        advance();

        // Basic path: expectation = outputs seen during the cycle the row is applied
        tbl[0] = '{1, 1, 14'h0100, 14'h3F00, MID, MID, 0, 1};
        tbl[1] = '{1, 1, 14'h1FFF, 14'h2000, MID, MID, 0, 0};
        tbl[2] = '{1, 1, 14'h1FFF, 14'h2000, conv(14'h0100), conv(14'h3F00), 0, 1};
        tbl[3] = '{1, 1, 14'h0AAA, 14'h3555, conv(14'h0100), conv(14'h3F00), 0, 0};
        tbl[4] = '{1, 1, 14'h0AAA, 14'h3555, conv(14'h0100), conv(14'h3F00), 1, 0};
        tbl[5] = '{1, 1, 14'h0AAA, 14'h3555, conv(14'h0100), conv(14'h3F00), 1, 0};
        tbl[6] = '{1, 1, 14'h0AAA, 14'h3555, conv(14'h1FFF), conv(14'h2000), 0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(0, tbl[i].en, 0, tbl[i].v, tbl[i].a, tbl[i].b);
            check($sformatf("tbl_dac_a[%0d]", i), 32'(da), 32'(tbl[i].exp_a));
            check($sformatf("tbl_dac_b[%0d]", i), 32'(db), 32'(tbl[i].exp_b));
            check($sformatf("tbl_strobe[%0d]", i), 32'(dclk), 32'(tbl[i].exp_strobe));
            check($sformatf("tbl_ready[%0d]", i), 32'(ready), 32'(tbl[i].exp_ready));
            advance();
        end

        // Underrun: no valid data for four periods
        for (int i = 0; i < 4 * DIV; i++) begin
            drive(0, 1, 0, 0, '0, '0); advance();
        end
        drive(0, 1, 0, 0, '0, '0);
        check("urun_flag", 32'(uflag), 32'd1);
        check("urun_cnt_once", 32'(ucnt), 32'd1);
        check("urun_hold_a", 32'(da), 32'(conv(14'h0AAA)));
        check("urun_hold_b", 32'(db), 32'(conv(14'h3555)));
        advance();

        // Recovery: the next valid pair is delivered
        done = 0;
        for (int i = 0; i < 3 * DIV && !done; i++) begin
            drive(0, 1, 0, 1, 14'h1234, 14'h0FED);
            if (da == conv(14'h1234) && db == conv(14'h0FED)) done = 1;
            else advance();
        end
        check("recover_seen", 32'(done), 32'd1);
        for (int i = 0; i < 3 * DIV; i++) begin
            drive(0, 1, 0, 1, 14'($urandom), 14'($urandom)); advance();
        end
        drive(0, 1, 0, 1, '0, '0);
        check("recover_cnt", 32'(ucnt), 32'd1);
        check("recover_flag_sticky", 32'(uflag), 32'd1);
        advance();

        // Clear asserted on the very edge of an underrun event
        done = 0;
        for (int i = 0; i < 4 * DIV && !done; i++) begin
            bit pend;
            pend = m_run && !m_starved && (mq_a.size() == 0) && ((m_age % DIV) == DIV - 1);
            drive(0, 1, pend, 0, '0, '0);
            advance();
            if (pend) begin
                done = 1;
                drive(0, 1, 0, 0, '0, '0);
                check("clr_prio_flag", 32'(uflag), 32'd0);
                check("clr_prio_cnt", 32'(ucnt), 32'd0);
                advance();
            end
        end
        check("clr_prio_reached", 32'(done), 32'd1);
        for (int i = 0; i < 2 * DIV; i++) begin
            drive(0, 1, 0, 0, '0, '0); advance();
        end
        drive(0, 1, 0, 0, '0, '0);
        check("urun_no_recount", 32'(ucnt), 32'd0);
        advance();

        // Disable at phase 1: finish the period, then midscale and idle strobes
        for (int i = 0; i < 2 * DIV; i++) begin
            drive(0, 1, 0, 1, 14'($urandom), 14'($urandom)); advance();
        end
        done = 0;
        for (int i = 0; i < 2 * DIV && !done; i++) begin
            if (m_run && (m_age % DIV) == 1) done = 1;
            else begin
                drive(0, 1, 0, 1, 14'h0555, 14'h0666); advance();
            end
        end
        check("dis_phase_found", 32'(done), 32'd1);
        hold_a = m_out_a;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 14'h0777, 14'h0888);
            check($sformatf("dis_strobe[%0d]", k), 32'(dclk), (k == 1 || k == 2) ? 32'd1 : 32'd0);
            check($sformatf("dis_dac_a[%0d]", k), 32'(da), (k == 3) ? 32'(MID) : 32'(hold_a));
            advance();
        end
        drive(0, 0, 0, 0, '0, '0);
        check("dis_idle_strobe", 32'(dwrt), 32'd0);
        check("dis_idle_dac_b", 32'(db), 32'(MID));
        advance();
        drive(0, 1, 0, 0, '0, '0);
        check("dis_buf_kept", 32'(ready), 32'd0);
        advance();

        // Reset mid-period with a buffered pair
        done = 0;
        for (int i = 0; i < 3 * DIV && !done; i++) begin
            if (m_run && (m_age % DIV) == 2 && mq_a.size() != 0) done = 1;
            else begin
                drive(0, 1, 0, 1, 14'h0123, 14'h0321); advance();
            end
        end
        check("rstmid_found", 32'(done), 32'd1);
        drive(1, 1, 0, 0, '0, '0); advance();
        drive(0, 1, 0, 0, '0, '0);
        check("rstmid_ready", 32'(ready), 32'd1);
        check("rstmid_dac_a", 32'(da), 32'(MID));
        check("rstmid_strobe", 32'(dclk), 32'd0);
        advance();
        drive(0, 1, 0, 0, '0, '0);
        check("rstmid_idle", 32'(dwrt), 32'd0);
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(199) == 0), ($urandom_range(99) < 90), ($urandom_range(99) < 3),
                  ($urandom_range(99) < 70), 14'($urandom), 14'($urandom));
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_dual_if.md
DAC_DUAL_IF -- requirements
Module: dac_dual_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, sample width per channel (matches FIFO_WIDTH of the DDS/DAC top).
REQ-002 SHALL have parameter DIV, default 4, DAC update period in clk_in cycles; legal values are even and at least 2.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable_in, input, 1, run request.
REQ-006 SHALL have port clear_in, input, 1, clears the sticky underrun flag and the underrun counter.
REQ-007 SHALL have port s_valid, input, 1, upstream sample pair valid.
REQ-008 SHALL have port s_ready, output, 1, block can accept a pair this cycle.
REQ-009 SHALL have ports s_dataA and s_dataB, input, DATA_WIDTH each, two's-complement samples for channels A and B.
REQ-010 SHALL have ports dac_dataA_out and dac_dataB_out, output, DATA_WIDTH each, registered DAC codes.
REQ-011 SHALL have ports dac_clk_out and dac_wrt_out, output, 1 each, DAC clock and write strobe.
REQ-012 SHALL have port underrun_out, output, 1, sticky underrun flag.
REQ-013 SHALL have port underrun_cnt, output, 16, saturating count of underrun events.

Function
REQ-014 SHALL hold one input pair in a single-entry buffer (buf_valid); s_ready = !buf_valid && enable_in; a transfer occurs when s_valid && s_ready.
REQ-015 SHALL run a divider counter cnt over 0..DIV-1 while in RUN or UNDERRUN; cnt is held at 0 in IDLE; the update tick is cnt==DIV-1.
REQ-016 SHALL implement three states:
- IDLE: divider held.
- RUN: samples delivered normally.
- UNDERRUN: no sample was available at the last tick.
REQ-017 SHALL transition IDLE->RUN when enable_in && buf_valid; on that edge it loads the buffer into the outputs, clears buf_valid, and sets cnt=0.
REQ-018 SHALL, in RUN or UNDERRUN at a tick with buf_valid, load the buffer into the outputs on that edge, clear buf_valid, and enter or stay in RUN.
REQ-019 SHALL, in RUN at a tick without buf_valid, hold the outputs, set underrun_out, increment underrun_cnt (saturating at 0xFFFF), and enter UNDERRUN.
REQ-020 SHALL count at most one underrun per UNDERRUN entry; repeated empty ticks while in UNDERRUN do not increment the counter.
REQ-021 SHALL, when enable_in falls in RUN or UNDERRUN, finish the current period and at the next tick enter IDLE and drive midscale on both outputs; a buffered sample is kept.
REQ-022 SHALL let clear_in take priority over a simultaneous underrun event: the flag and counter are 0 after that edge.
REQ-023 SHALL drive dac_clk_out = dac_wrt_out = (cnt >= DIV/2) in RUN and UNDERRUN and 0 in IDLE, so the output data is stable DIV/2 cycles before each rising strobe.
REQ-024 SHALL define midscale as the code for a zero sample (see REQ-027/028).
REQ-025 SHALL sustain one pair per DIV cycles; upstream refill of the buffer between ticks is guaranteed because DIV >= 2.

Reset
REQ-026 SHALL, on rst_in, asynchronously to the divider phase but on a clock edge, set: state=IDLE, cnt=0, buf_valid=0, outputs=midscale, dac_clk_out=0, dac_wrt_out=0, underrun_out=0, underrun_cnt=0; reset mid-period discards the buffered sample.

Configuration
REQ-027 SHALL, with DAC_OFFSET_BINARY_EN defined, invert the MSB of each sample when loading the outputs (offset-binary codes); midscale is 2^(DATA_WIDTH-1), i.e. 0x2000 at width 14.
REQ-028 SHALL, without DAC_OFFSET_BINARY_EN, pass two's-complement samples unchanged; midscale is 0.

Structure
REQ-029 SHALL place the state enum, the midscale function, and the default DATA_WIDTH/DIV constants in shared package dac_pkg.
REQ-030 SHALL implement the divider counter and the strobe generation in sub-module dac_clk_div (outputs cnt, tick, strobe).

Verification
REQ-031 SHALL cover reset: with DAC_OFFSET_BINARY_EN, after reset -> dac_dataA_out=dac_dataB_out=0x2000, strobes 0, underrun_cnt=0.
REQ-032 SHALL cover the basic path: enable_in=1, pairs (0x0100,0x3F00) then (0x1FFF,0x2000) always valid, DIV=4, DAC_OFFSET_BINARY_EN -> outputs 0x2100/0x1F00, then 0x3FFF/0x0000 exactly 4 cycles later; strobe high on cnt 2..3.
REQ-033 SHALL cover underrun: s_valid dropped for 3 periods -> outputs hold the last pair, underrun_out=1, underrun_cnt=1; the next valid pair returns the state to RUN.
REQ-034 SHALL cover clear priority: clear_in asserted on the same cycle as an underrun tick -> underrun_out=0 and underrun_cnt=0 on the following cycle.
REQ-035 SHALL cover disable: enable_in dropped mid-period at cnt=1 -> outputs go to midscale and the strobes go low after the tick at cnt=3, with state IDLE.
REQ-036 SHALL cover reset mid-operation: rst_in asserted at cnt=2 with buf_valid=1 -> IDLE, buf_valid=0, and s_ready=1 once enable_in=1.
